ahb_lite_master: RTL and testbench

- Single-master AHB-Lite bus interface.
- Converts a simple valid/ready command stream into pipelined AHB-Lite SINGLE transfers.
- Sits directly upstream of the address decoder and drives the HADDR that the decoder consumes. It also consumes the muxed HRDATA/HREADY/HRESP returned from the slaves.
- Address phase of transfer N+1 overlaps the data phase of transfer N.

---
 rtl/ahb_lite_master.sv | 228 ++++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// -----------------------------------------------------------------------------
// ahb_lite_master
//
// Single-master AHB-Lite bus interface. Turns a valid/ready command stream
// into pipelined AHB-Lite SINGLE transfers. The address phase of transfer N+1
// overlaps the data phase of transfer N, so with zero wait states one
// transfer completes every cycle. Each completed transfer produces a
// one-cycle response pulse with no backpressure.
//
// Build option:
//   AHB_MASTER_ERR_EN - when defined, two-cycle ERROR responses are honoured:
//                       the pending address phase is suppressed (HTRANS=IDLE)
//                       during the ERROR response, retained, and re-issued
//                       afterwards. When undefined, HRESP is ignored and
//                       rsp_err is always 0.
//
// Ports:
//   HCLK, HRESETn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (accept on valid & ready)
//   cmd_write/addr/size/wdata command fields; size with bit2 set clamps to word
//   HADDR/HTRANS/HWRITE/HSIZE address-phase outputs
//   HBURST/HPROT/HMASTLOCK   constant SINGLE / data,privileged / unlocked
//   HWDATA                   data-phase write data
//   HRDATA/HREADY/HRESP      muxed slave response
//   rsp_valid/write/rdata/err completion pulse and its attributes
//   busy                     a transfer is in address or data phase
// -----------------------------------------------------------------------------
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // AHB-Lite master outputs
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  // AHB-Lite slave response (already muxed)
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  // response stream
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Sizes above a word are not supported by the data bus; fold them to word.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return size[2] ? 3'b010 : size;
  endfunction

  // Writes report zero data so the consumer never sees stale bus contents.
  function automatic logic [DATA_WIDTH-1:0] capture_rdata(
    input logic                  is_write,
    input logic [DATA_WIDTH-1:0] bus_data
  );
    return is_write ? '0 : bus_data;
  endfunction

  // Address-phase register
  logic                  ap_valid_q, ap_valid_d;
  logic [ADDR_WIDTH-1:0] ap_addr_q,  ap_addr_d;
  logic                  ap_write_q, ap_write_d;
  logic [2:0]            ap_size_q,  ap_size_d;
  logic [DATA_WIDTH-1:0] ap_wdata_q, ap_wdata_d;

  // Data-phase register
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [DATA_WIDTH-1:0] dp_wdata_q, dp_wdata_d;

  // Response register
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  logic                  err_hold;
  logic                  err_resp;
  logic                  cmd_accept;

`ifdef AHB_MASTER_ERR_EN
  logic err_hold_q, err_hold_d;

  assign err_hold = err_hold_q;
  assign err_resp = HRESP;

  // First ERROR cycle (HREADY low) arms the hold; the completing second
  // cycle (HREADY high) always releases it.
  always_comb begin
    err_hold_d = err_hold_q;
    if (HREADY) begin
      err_hold_d = 1'b0;
    end else if (HRESP && dp_valid_q) begin
      err_hold_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      err_hold_q <= 1'b0;
    end else begin
      err_hold_q <= err_hold_d;
    end
  end
`else
  logic unused_hresp;

  assign err_hold     = 1'b0;
  assign err_resp     = 1'b0;
  assign unused_hresp = HRESP;
`endif

  assign cmd_ready  = HREADY & ~err_hold;
  assign cmd_accept = cmd_valid & cmd_ready;

  always_comb begin
    ap_valid_d  = ap_valid_q;
    ap_addr_d   = ap_addr_q;
    ap_write_d  = ap_write_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (HREADY) begin
      // Completion of the transfer currently in its data phase
      if (dp_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = dp_write_q;
        rsp_rdata_d = capture_rdata(dp_write_q, HRDATA);
        rsp_err_d   = err_resp;
      end

      if (err_hold) begin
        // The address phase was shown as IDLE this cycle, so it did not move
        // into the data phase; keep it for re-issue next cycle.
        dp_valid_d = 1'b0;
      end else begin
        dp_valid_d = ap_valid_q;
        // Data-phase fields only move with a real transfer so HWDATA keeps
        // its last value across idle cycles.
        if (ap_valid_q) begin
          dp_write_d = ap_write_q;
          dp_wdata_d = ap_wdata_q;
        end

        ap_valid_d = cmd_accept;
        // Address fields hold when nothing is accepted, keeping HADDR quiet.
        if (cmd_accept) begin
          ap_addr_d  = cmd_addr;
          ap_write_d = cmd_write;
          ap_size_d  = clamp_size(cmd_size);
          ap_wdata_d = cmd_wdata;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ap_valid_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_write_q  <= 1'b0;
      ap_size_q   <= 3'b000;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      ap_addr_q   <= ap_addr_d;
      ap_write_q  <= ap_write_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign HADDR     = ap_addr_q;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = ap_size_q;
  assign HTRANS    = (ap_valid_q && !err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = dp_wdata_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = ap_valid_q | dp_valid_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// -----------------------------------------------------------------------------
// tb_ahb_lite_master
//
// Directed bench for ahb_lite_master. A table of per-edge records holds the
// inputs applied before a rising edge and the outputs expected after it;
// hand-written sequences cover ERROR responses and reset during a wait state.
// -----------------------------------------------------------------------------
module tb_ahb_lite_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        rstn;
    logic        cv;
    logic        cw;
    logic [31:0] ca;
    logic [2:0]  cs;
    logic [31:0] cwd;
    logic        hrdy;
    logic [31:0] hrdata;
    logic        e_ready;
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    logic        e_hwrite;
    logic [2:0]  e_hsize;
    logic        e_rv;
    logic        e_rw;
    logic [31:0] e_rdata;
    logic        e_busy;
    logic        chk_wd;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(
    input logic rstn, cv, cw, input logic [31:0] ca, input logic [2:0] cs,
    input logic [31:0] cwd, input logic hrdy, input logic [31:0] hrdata,
    input logic e_ready, input logic [1:0] e_htrans, input logic [31:0] e_haddr,
    input logic e_hwrite, input logic [2:0] e_hsize, input logic e_rv, e_rw,
    input logic [31:0] e_rdata, input logic e_busy, chk_wd,
    input logic [31:0] e_wd);
    vec_t v;
    v.rstn = rstn; v.cv = cv; v.cw = cw; v.ca = ca; v.cs = cs; v.cwd = cwd;
    v.hrdy = hrdy; v.hrdata = hrdata; v.e_ready = e_ready;
    v.e_htrans = e_htrans; v.e_haddr = e_haddr; v.e_hwrite = e_hwrite;
    v.e_hsize = e_hsize; v.e_rv = e_rv; v.e_rw = e_rw; v.e_rdata = e_rdata;
    v.e_busy = e_busy; v.chk_wd = chk_wd; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rstn, cv, cw, input logic [31:0] ca,
                       input logic [2:0] cs, input logic [31:0] cwd,
                       input logic hr, hresp, input logic [31:0] rd);
    HRESETn = rstn; cmd_valid = cv; cmd_write = cw; cmd_addr = ca;
    cmd_size = cs; cmd_wdata = cwd; HREADY = hr; HRESP = hresp; HRDATA = rd;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    // reset with a write pending, then the write goes through
    vecs[0]  = mk(0,1,1,32'h4000_0010,3'd2,32'hDEAD_BEEF,1,32'h0, 1,2'b00,32'h0,0,3'd0, 0,0,32'h0, 0,1,32'h0);
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = mk(1,1,1,32'h4000_0010,3'd2,32'hDEAD_BEEF,1,32'h0, 1,2'b10,32'h4000_0010,1,3'd2, 0,0,32'h0, 1,1,32'h0);
    vecs[4]  = mk(1,0,0,32'h0,3'd0,32'h0,1,32'h0, 1,2'b00,32'h0,0,3'd0, 0,0,32'h0, 1,1,32'hDEAD_BEEF);
    vecs[5]  = mk(1,0,0,32'h0,3'd0,32'h0,1,32'hFFFF_0000, 1,2'b00,32'h0,0,3'd0, 1,1,32'h0, 0,1,32'hDEAD_BEEF);
    // back-to-back reads, HRDATA = addr ^ FFFF_FFFF
    vecs[6]  = mk(1,1,0,32'h0000_0000,3'd2,32'h0,1,32'h0, 1,2'b10,32'h0000_0000,0,3'd2, 0,0,32'h0, 1,0,32'h0);
    vecs[7]  = mk(1,1,0,32'h8000_0004,3'd2,32'h0,1,32'h0, 1,2'b10,32'h8000_0004,0,3'd2, 0,0,32'h0, 1,0,32'h0);
    vecs[8]  = mk(1,1,0,32'hC000_0008,3'd2,32'h0,1,32'hFFFF_FFFF, 1,2'b10,32'hC000_0008,0,3'd2, 1,0,32'hFFFF_FFFF, 1,0,32'h0);
    vecs[9]  = mk(1,0,0,32'h0,3'd0,32'h0,1,32'h7FFF_FFFB, 1,2'b00,32'h0,0,3'd0, 1,0,32'h7FFF_FFFB, 1,0,32'h0);
    vecs[10] = mk(1,0,0,32'h0,3'd0,32'h0,1,32'h3FFF_FFF7, 1,2'b00,32'h0,0,3'd0, 1,0,32'h3FFF_FFF7, 0,0,32'h0);
    vecs[11] = mk(1,0,0,32'h0,3'd0,32'h0,1,32'h0, 1,2'b00,32'h0,0,3'd0, 0,0,32'h0, 0,0,32'h0);
    // read, then write (size clamps 111 -> 010), then two wait states
    vecs[12] = mk(1,1,0,32'h1000_0000,3'd1,32'h0,1,32'h0, 1,2'b10,32'h1000_0000,0,3'd1, 0,0,32'h0, 1,0,32'h0);
    vecs[13] = mk(1,1,1,32'h2000_0004,3'd7,32'h1234_5678,1,32'h0, 1,2'b10,32'h2000_0004,1,3'd2, 0,0,32'h0, 1,0,32'h0);
    vecs[14] = mk(1,1,0,32'h3000_0008,3'd2,32'h0,0,32'hDEAD_0000, 0,2'b10,32'h2000_0004,1,3'd2, 0,0,32'h0, 1,0,32'h0);
    vecs[15] = vecs[14];
    vecs[16] = mk(1,1,0,32'h3000_0008,3'd2,32'h0,1,32'hA5A5_5A5A, 1,2'b10,32'h3000_0008,0,3'd2, 1,0,32'hA5A5_5A5A, 1,1,32'h1234_5678);
    vecs[17] = mk(1,0,0,32'h0,3'd0,32'h0,1,32'hFFFF_FFFF, 1,2'b00,32'h0,0,3'd0, 1,1,32'h0, 1,0,32'h0);
    vecs[18] = mk(1,0,0,32'h0,3'd0,32'h0,1,32'h0BAD_F00D, 1,2'b00,32'h0,0,3'd0, 1,0,32'h0BAD_F00D, 0,0,32'h0);
    vecs[19] = mk(1,0,0,32'h0,3'd0,32'h0,1,32'h0, 1,2'b00,32'h0,0,3'd0, 0,0,32'h0, 0,0,32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rstn, vecs[i].cv, vecs[i].cw, vecs[i].ca, vecs[i].cs,
            vecs[i].cwd, vecs[i].hrdy, 1'b0, vecs[i].hrdata);
      #1;
      chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_ready));
      tick();
      chk($sformatf("v%0d htrans", i), 32'(HTRANS), 32'(vecs[i].e_htrans));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_htrans == 2'b10 || !vecs[i].rstn)
        chk($sformatf("v%0d haddr", i), HADDR, vecs[i].e_haddr);
      if (vecs[i].e_htrans == 2'b10) begin
        chk($sformatf("v%0d hwrite", i), 32'(HWRITE), 32'(vecs[i].e_hwrite));
        chk($sformatf("v%0d hsize", i), 32'(HSIZE), 32'(vecs[i].e_hsize));
      end
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d rsp_write", i), 32'(rsp_write), 32'(vecs[i].e_rw));
        chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
        chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'h0);
      end
      if (vecs[i].chk_wd)
        chk($sformatf("v%0d hwdata", i), HWDATA, vecs[i].e_wd);
    end
    chk("hburst", 32'(HBURST), 32'h0);
    chk("hprot", 32'(HPROT), 32'h3);
    chk("hmastlock", 32'(HMASTLOCK), 32'h0);

    // ERROR response on a write followed by a pending read
    drive(1,1,1,32'h4000_0000,3'd2,32'h1111_2222,1,0,32'h0); tick();
    chk("err htrans0", 32'(HTRANS), 32'h2);
    chk("err haddr0", HADDR, 32'h4000_0000);
    drive(1,1,0,32'h8000_0000,3'd2,32'h0,1,0,32'h0); tick();
    chk("err htrans1", 32'(HTRANS), 32'h2);
    chk("err haddr1", HADDR, 32'h8000_0000);
`ifdef AHB_MASTER_ERR_EN
    drive(1,0,0,32'h0,3'd0,32'h0,0,1,32'h0); tick();
    chk("err htrans idle", 32'(HTRANS), 32'h0);
    chk("err rsp_valid1", 32'(rsp_valid), 32'h0);
    chk("err busy", 32'(busy), 32'h1);
    drive(1,1,0,32'h9000_0000,3'd2,32'h0,1,1,32'h0); #1;
    chk("err cmd_ready", 32'(cmd_ready), 32'h0);
    tick();
    chk("err rsp_valid2", 32'(rsp_valid), 32'h1);
    chk("err rsp_err", 32'(rsp_err), 32'h1);
    chk("err rsp_write", 32'(rsp_write), 32'h1);
    chk("err reissue htrans", 32'(HTRANS), 32'h2);
    chk("err reissue haddr", HADDR, 32'h8000_0000);
    drive(1,0,0,32'h0,3'd0,32'h0,1,0,32'h0); tick();
    chk("err rsp_valid3", 32'(rsp_valid), 32'h0);
    chk("err htrans after", 32'(HTRANS), 32'h0);
    drive(1,0,0,32'h0,3'd0,32'h0,1,0,32'h55AA_55AA); tick();
`else
    drive(1,0,0,32'h0,3'd0,32'h0,0,1,32'h0); tick();
    chk("noerr htrans held", 32'(HTRANS), 32'h2);
    chk("noerr haddr held", HADDR, 32'h8000_0000);
    chk("noerr rsp_valid1", 32'(rsp_valid), 32'h0);
    drive(1,0,0,32'h0,3'd0,32'h0,1,1,32'h0); #1;
    chk("noerr cmd_ready", 32'(cmd_ready), 32'h1);
    tick();
    chk("noerr rsp_valid2", 32'(rsp_valid), 32'h1);
    chk("noerr rsp_err", 32'(rsp_err), 32'h0);
    chk("noerr rsp_write", 32'(rsp_write), 32'h1);
    chk("noerr htrans", 32'(HTRANS), 32'h0);
    drive(1,0,0,32'h0,3'd0,32'h0,1,0,32'h55AA_55AA); tick();
`endif
    chk("read rsp_valid", 32'(rsp_valid), 32'h1);
    chk("read rsp_err", 32'(rsp_err), 32'h0);
    chk("read rsp_write", 32'(rsp_write), 32'h0);
    chk("read rsp_rdata", rsp_rdata, 32'h55AA_55AA);
    chk("read busy", 32'(busy), 32'h0);

    // reset while a read sits in a waited data phase
    drive(1,1,0,32'h5000_0000,3'd2,32'h0,1,0,32'h0); tick();
    chk("mrst htrans0", 32'(HTRANS), 32'h2);
    drive(1,1,0,32'h6000_0000,3'd2,32'h0,1,0,32'h0); tick();
    drive(1,0,0,32'h0,3'd0,32'h0,0,0,32'h0); tick();
    chk("mrst wait htrans", 32'(HTRANS), 32'h2);
    chk("mrst wait haddr", HADDR, 32'h6000_0000);
    drive(0,0,0,32'h0,3'd0,32'h0,0,0,32'h0); tick();
    chk("mrst htrans", 32'(HTRANS), 32'h0);
    chk("mrst busy", 32'(busy), 32'h0);
    chk("mrst haddr", HADDR, 32'h0);
    chk("mrst rsp_valid0", 32'(rsp_valid), 32'h0);
    drive(1,0,0,32'h0,3'd0,32'h0,1,0,32'hCAFE_F00D); tick();
    chk("mrst rsp_valid1", 32'(rsp_valid), 32'h0);
    chk("mrst busy1", 32'(busy), 32'h0);
    tick();
    chk("mrst rsp_valid2", 32'(rsp_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
